uart_tx_pkt_unpacker: RTL



---
 rtl/uart_tx_pkt_unpacker.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_pkt_unpacker.sv
// Pops one packet from a UART's data FIFO and streams its payload bytes,
// least-significant first, to the UART TX core over a valid/ready handshake.
module uart_tx_pkt_unpacker #(
    parameter int ASYNC_FIFO_WIDTH = 51,
    parameter int VALUE_WIDTH      = 48,
    parameter int UART_DATA_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_en,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [ASYNC_FIFO_WIDTH-1:0] fifo_dout,
    output logic [UART_DATA_WIDTH-1:0]  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        pkt_done
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        LOAD,
        SEND
    } state_t;

    state_t                   state_reg;
    logic [VALUE_WIDTH-1:0]   shreg_reg;
    logic [2:0]               count_reg;

    logic [2:0]               sel;
    logic [2:0]               byte_count;
    logic [VALUE_WIDTH-1:0]   shreg_next;

    assign sel        = fifo_dout[VALUE_WIDTH +: 3];
    assign shreg_next = shreg_reg >> UART_DATA_WIDTH;

    // sel 0 is a single-byte parallel-mode packet; 6 and 7 both mean a full frame.
    always_comb begin
        byte_count = sel;
        case (sel)
            3'd0:       byte_count = 3'd1;
            3'd6, 3'd7: byte_count = 3'd6;
            default:    byte_count = sel;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            count_reg  <= '0;
            fifo_rd_en <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            pkt_done   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        state_reg  <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                POP: begin
                    state_reg <= LOAD;
                end
                LOAD: begin
                    shreg_reg <= fifo_dout[VALUE_WIDTH-1:0];
                    count_reg <= byte_count;
                    tx_data   <= fifo_dout[UART_DATA_WIDTH-1:0];
                    tx_valid  <= 1'b1;
                    state_reg <= SEND;
                end
                SEND: begin
                    // tx_data/tx_valid only move on an accepted byte.
                    if (tx_ready) begin
                        shreg_reg <= shreg_next;
                        count_reg <= count_reg - 3'd1;
                        tx_data   <= shreg_next[UART_DATA_WIDTH-1:0];
                        if (count_reg == 3'd1) begin
                            tx_valid  <= 1'b0;
                            pkt_done  <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
